m68k_bus_master: RTL and testbench

- Synthesizable 68000-style bus initiator: the requesting end of the 68k bus that M68kDramController_Verilog responds to.
- Converts a simple single-cycle request interface into full asynchronous-bus read/write cycles.
- Drives AS_L, UDS_L/LDS_L, WE_L, DramSelect_L, Address and DataIn; waits for Dtack_L; returns read data or a timeout error.
- Serves as the DMA/test engine in place of the CPU, and as the stimulus source for controller benches.

---
 rtl/m68k_bus_master_if.sv | 40 ++++
 rtl/m68k_bus_master.sv | 126 ++++++++++++
 tb/tb_m68k_bus_master.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/m68k_bus_master_if.sv
// Signal bundle between a 68000-style bus initiator and the two parties it serves:
// the request/response client and the DRAM controller's asynchronous bus.
interface m68k_bus_master_if;
  // Handshake: when BusReady_L=0 and the master is idle, a cycle with Req_H=1 is accepted
  // on that clock edge, and Busy_H rises on the next cycle. Requests that arrive while
  // Busy_H=1 are dropped. Exactly one of Ack_H or Err_H pulses for one cycle per accepted
  // request. A release timeout is the exception: it pulses Err_H after Ack_H has already pulsed.
  logic        BusReady_L;
  logic        Req_H;
  logic        ReqRnW_H;
  logic [31:0] ReqAddr;
  logic [1:0]  ReqByteEn;
  logic [15:0] ReqWData;
  logic        Busy_H;
  logic        Ack_H;
  logic        Err_H;
  logic [15:0] RData;
  logic [31:0] Address;
  logic [15:0] DataIn;
  logic        UDS_L;
  logic        LDS_L;
  logic        AS_L;
  logic        WE_L;
  logic        DramSelect_L;
  logic [15:0] DataOut;
  logic        Dtack_L;
  logic [2:0]  dbg_state;

  modport master (
    input  BusReady_L, Req_H, ReqRnW_H, ReqAddr, ReqByteEn, ReqWData, DataOut, Dtack_L,
    output Busy_H, Ack_H, Err_H, RData, Address, DataIn, UDS_L, LDS_L, AS_L, WE_L,
           DramSelect_L, dbg_state
  );

  modport slave (
    output BusReady_L, Req_H, ReqRnW_H, ReqAddr, ReqByteEn, ReqWData, DataOut, Dtack_L,
    input  Busy_H, Ack_H, Err_H, RData, Address, DataIn, UDS_L, LDS_L, AS_L, WE_L,
           DramSelect_L, dbg_state
  );
endinterface

// File: rtl/m68k_bus_master.sv
// 68000-style bus initiator: turns a single-cycle request into a full AS/DS/DTACK bus
// cycle towards the DRAM controller, with strobe and release timeouts.
module m68k_bus_master #(
  parameter logic [5:0] DRAM_BASE   = 6'b000010,
  parameter int         TIMEOUT     = 64,
  parameter int         REL_TIMEOUT = 16
) (
  input  logic               Clock,
  input  logic               Reset_L,
  m68k_bus_master_if.master  bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(REL_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_STROBE, S_END, S_RELEASE, S_ERR
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [RW-1:0] rel_cnt;
  logic          rnw_q;
  logic [1:0]    be_q;
  logic          accept;
  logic          req_ok;
  logic          unused_addr0;

  assign accept       = !bus.BusReady_L && bus.Req_H;
  assign req_ok       = (bus.ReqAddr[31:26] == DRAM_BASE) && (bus.ReqByteEn != 2'b00);
  assign unused_addr0 = bus.ReqAddr[0];
  assign bus.dbg_state = state;

  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      state            <= S_IDLE;
      cnt              <= '0;
      rel_cnt          <= '0;
      rnw_q            <= 1'b1;
      be_q             <= 2'b00;
      bus.AS_L         <= 1'b1;
      bus.UDS_L        <= 1'b1;
      bus.LDS_L        <= 1'b1;
      bus.WE_L         <= 1'b1;
      bus.DramSelect_L <= 1'b1;
      bus.Address      <= '0;
      bus.DataIn       <= '0;
      bus.RData        <= '0;
      bus.Busy_H       <= 1'b0;
      bus.Ack_H        <= 1'b0;
      bus.Err_H        <= 1'b0;
    end else begin
      bus.Ack_H <= 1'b0;
      bus.Err_H <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            rnw_q      <= bus.ReqRnW_H;
            be_q       <= bus.ReqByteEn;
            bus.Busy_H <= 1'b1;
            // Rejected requests never touch the bus: address/data/WE_L keep old values.
            if (req_ok) begin
              bus.Address <= {bus.ReqAddr[31:1], 1'b0};
              bus.DataIn  <= bus.ReqWData;
              bus.WE_L    <= bus.ReqRnW_H;
              state       <= S_ADDR;
            end else begin
              bus.Err_H <= 1'b1;
              state     <= S_ERR;
            end
          end
        end
        S_ADDR: begin
          bus.AS_L         <= 1'b0;
          bus.DramSelect_L <= 1'b0;
          bus.UDS_L        <= ~be_q[1];
          bus.LDS_L        <= ~be_q[0];
          cnt              <= '0;
          state            <= S_STROBE;
        end
        S_STROBE: begin
          if (!bus.Dtack_L) begin
            if (rnw_q) bus.RData <= bus.DataOut;
            bus.AS_L         <= 1'b1;
            bus.DramSelect_L <= 1'b1;
            bus.UDS_L        <= 1'b1;
            bus.LDS_L        <= 1'b1;
            bus.Ack_H        <= 1'b1;
            state            <= S_END;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            bus.AS_L         <= 1'b1;
            bus.DramSelect_L <= 1'b1;
            bus.UDS_L        <= 1'b1;
            bus.LDS_L        <= 1'b1;
            bus.WE_L         <= 1'b1;
            bus.Err_H        <= 1'b1;
            state            <= S_ERR;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_END: begin
          bus.WE_L <= 1'b1;
          rel_cnt  <= '0;
          state    <= S_RELEASE;
        end
        S_RELEASE: begin
          // A stuck Dtack_L is reported via the shared ERR state; the earlier Ack stands.
          if (bus.Dtack_L) begin
            bus.Busy_H <= 1'b0;
            state      <= S_IDLE;
          end else if (rel_cnt == RW'(REL_TIMEOUT - 1)) begin
            bus.Err_H <= 1'b1;
            state     <= S_ERR;
          end else begin
            rel_cnt <= rel_cnt + RW'(1);
          end
        end
        S_ERR: begin
          bus.Busy_H <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_m68k_bus_master.sv
// Directed bench for m68k_bus_master: a scripted DTACK responder plus hand-computed
// expectations for timing, strobes, read data and error paths.
module tb_m68k_bus_master;
  logic clk;
  logic rst_n;
  m68k_bus_master_if bus();

  m68k_bus_master dut (
    .Clock   (clk),
    .Reset_L (rst_n),
    .bus     (bus.master)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];

  // responder controls
  logic        resp_en;
  logic        resp_stuck;
  int          resp_dly;
  logic [15:0] resp_data;
  int          resp_cnt;

  // monitor state
  int          as_cnt;
  int          hold_bad;
  int          both_cnt;
  logic [31:0] snap_addr;
  logic [15:0] snap_din;
  logic        snap_we, snap_uds, snap_lds, snap_dsel;

  // per-transaction results
  int          ack_n, err_n, ack_at, err_at;
  logic        busy_first, done_ok, we_ack;
  logic [15:0] din_ack;

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // DTACK responder: asserts Dtack_L once AS_L has been low for resp_dly+1 samples
  always @(negedge clk) begin
    if (!rst_n) begin
      bus.Dtack_L = 1'b1;
      bus.DataOut = 16'h0000;
      resp_cnt    = 0;
    end else if (bus.AS_L == 1'b0) begin
      resp_cnt++;
      if (resp_en && resp_cnt > resp_dly) begin
        bus.Dtack_L = 1'b0;
        bus.DataOut = resp_data;
      end
    end else begin
      resp_cnt = 0;
      if (!resp_stuck) bus.Dtack_L = 1'b1;
    end
  end

  // bus monitor
  always @(negedge clk) begin
    if (bus.Ack_H && bus.Err_H) both_cnt++;
    if (rst_n && bus.AS_L == 1'b0) begin
      if (as_cnt == 0) begin
        snap_addr = bus.Address; snap_din = bus.DataIn; snap_we = bus.WE_L;
        snap_uds = bus.UDS_L; snap_lds = bus.LDS_L; snap_dsel = bus.DramSelect_L;
      end else if (bus.Address != snap_addr || bus.DataIn != snap_din || bus.WE_L != snap_we ||
                   bus.UDS_L != snap_uds || bus.LDS_L != snap_lds || bus.DramSelect_L != snap_dsel) begin
        hold_bad++;
      end
      as_cnt++;
    end
  end

  // driver tasks
  task automatic set_req(input logic rnw, input logic [31:0] addr, input logic [1:0] be,
                         input logic [15:0] wd);
    bus.ReqRnW_H  = rnw;
    bus.ReqAddr   = addr;
    bus.ReqByteEn = be;
    bus.ReqWData  = wd;
    as_cnt   = 0;
    hold_bad = 0;
  endtask

  task automatic start_req(input logic rnw, input logic [31:0] addr, input logic [1:0] be,
                           input logic [15:0] wd);
    @(negedge clk);
    set_req(rnw, addr, be, wd);
    bus.Req_H = 1'b1;
    @(posedge clk);
    #1 bus.Req_H = 1'b0;
  endtask

  task automatic wait_done(input logic rnw);
    ack_n = 0; err_n = 0; ack_at = 0; err_at = 0; busy_first = 1'b0; done_ok = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (i == 1) busy_first = bus.Busy_H;
      if (bus.Ack_H) begin
        ack_n++; ack_at = i; din_ack = bus.DataIn; we_ack = bus.WE_L;
        if (rnw && exp_q.size() > 0) check("sb_rdata", {16'h0, bus.RData}, {16'h0, exp_q.pop_front()});
      end
      if (bus.Err_H) begin
        err_n++; err_at = i;
      end
      if (i > 1 && !bus.Busy_H) begin
        done_ok = 1'b1;
        break;
      end
    end
    check("done_in_budget", {31'b0, done_ok}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.BusReady_L = 1'b1;
    bus.Req_H = 1'b0;
    set_req(1'b1, 32'h0, 2'b00, 16'h0);
    resp_en = 1'b1; resp_stuck = 1'b0; resp_dly = 0; resp_data = 16'h0;
    both_cnt = 0;
    repeat (3) @(negedge clk);
    check("rst_as", {31'b0, bus.AS_L}, 32'd1);
    check("rst_ds", {30'b0, bus.UDS_L, bus.LDS_L}, 32'd3);
    check("rst_we_sel", {30'b0, bus.WE_L, bus.DramSelect_L}, 32'd3);
    check("rst_addr", bus.Address, 32'h0);
    check("rst_din_rdata", {bus.DataIn, bus.RData}, 32'h0);
    check("rst_flags", {29'b0, bus.Busy_H, bus.Ack_H, bus.Err_H}, 32'd0);
    check("rst_state", {29'b0, bus.dbg_state}, 32'd0);
    rst_n = 1'b1;

    // bus not ready: request held but ignored
    set_req(1'b1, 32'h0800_0000, 2'b11, 16'h0);
    bus.Req_H = 1'b1;
    resp_dly = 0; resp_data = 16'h1234;
    begin
      int as_lo = 0, busy_hi = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (!bus.AS_L) as_lo++;
        if (bus.Busy_H) busy_hi++;
      end
      check("notready_as", as_lo, 0);
      check("notready_busy", busy_hi, 0);
    end
    bus.BusReady_L = 1'b0;
    exp_q.push_back(16'h1234);
    @(posedge clk);
    #1 bus.Req_H = 1'b0;
    wait_done(1'b1);
    check("t1_busy", {31'b0, busy_first}, 32'd1);
    check("t1_ack_at", ack_at, 3);
    check("t1_ack_err", {ack_n[15:0], err_n[15:0]}, {16'd1, 16'd0});
    check("t1_as_cnt", as_cnt, 1);

    // write, Dtack after 5 cycles of strobe
    resp_dly = 5;
    start_req(1'b0, 32'h0800_1235, 2'b11, 16'hBEEF);
    wait_done(1'b0);
    check("wr_addr", snap_addr, 32'h0800_1234);
    check("wr_we_ds", {29'b0, snap_we, snap_uds, snap_lds}, 32'd0);
    check("wr_sel", {31'b0, snap_dsel}, 32'd0);
    check("wr_din", {16'h0, snap_din}, 32'hBEEF);
    check("wr_as_cnt", as_cnt, 6);
    check("wr_hold", hold_bad, 0);
    check("wr_ack_at", ack_at, 8);
    check("wr_ack_err", {ack_n[15:0], err_n[15:0]}, {16'd1, 16'd0});
    check("wr_end_hold", {15'b0, we_ack, din_ack}, {16'h0, 16'hBEEF});
    check("wr_rdata_kept", {16'h0, bus.RData}, 32'h1234);

    // lower-byte read
    resp_dly = 2; resp_data = 16'h00A5;
    exp_q.push_back(16'h00A5);
    start_req(1'b1, 32'h0800_0010, 2'b01, 16'h0);
    wait_done(1'b1);
    check("rd_addr", snap_addr, 32'h0800_0010);
    check("rd_we_ds", {29'b0, snap_we, snap_uds, snap_lds}, 32'b110);
    check("rd_ack_at", ack_at, 5);
    check("rd_rdata", {16'h0, bus.RData}, 32'h00A5);

    // Dtack never comes
    resp_en = 1'b0;
    start_req(1'b1, 32'h0800_0020, 2'b10, 16'h0);
    wait_done(1'b1);
    check("to_as_cnt", as_cnt, 64);
    check("to_err_at", err_at, 66);
    check("to_ack_err", {ack_n[15:0], err_n[15:0]}, {16'd0, 16'd1});
    check("to_rdata", {16'h0, bus.RData}, 32'h00A5);
    check("to_idle", {29'b0, bus.dbg_state}, 32'd0);
    resp_en = 1'b1;

    // rejected: outside DRAM, then no byte enables
    start_req(1'b1, 32'h0000_0400, 2'b11, 16'h0);
    wait_done(1'b1);
    check("bad_addr_busy", {31'b0, busy_first}, 32'd1);
    check("bad_addr_err_at", err_at, 1);
    check("bad_addr_as", as_cnt, 0);
    check("bad_addr_ack", ack_n, 0);
    start_req(1'b0, 32'h0800_0040, 2'b00, 16'h5555);
    wait_done(1'b0);
    check("bad_be_err_at", err_at, 1);
    check("bad_be_as", as_cnt, 0);

    // Dtack stuck low after the cycle: Ack then release-timeout Err
    resp_dly = 0; resp_data = 16'h7E7E; resp_stuck = 1'b1;
    exp_q.push_back(16'h7E7E);
    start_req(1'b1, 32'h0800_0100, 2'b11, 16'h0);
    wait_done(1'b1);
    check("rel_ack_at", ack_at, 3);
    check("rel_err_at", err_at, 20);
    check("rel_ack_err", {ack_n[15:0], err_n[15:0]}, {16'd1, 16'd1});
    resp_stuck = 1'b0;
    repeat (2) @(negedge clk);

    // async reset during strobe phase
    resp_en = 1'b0;
    start_req(1'b0, 32'h0800_0200, 2'b11, 16'hCAFE);
    repeat (3) @(negedge clk);
    check("rst_mid_in_strobe", {31'b0, bus.AS_L}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_strobes", {28'b0, bus.AS_L, bus.UDS_L, bus.LDS_L, bus.DramSelect_L}, 32'hF);
    check("rst_mid_busy", {31'b0, bus.Busy_H}, 32'd0);
    begin
      int pulses = 0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        if (bus.Ack_H || bus.Err_H) pulses++;
      end
      check("rst_mid_pulses", pulses, 0);
    end
    rst_n = 1'b1;
    resp_en = 1'b1; resp_dly = 1; resp_data = 16'h5A5A;
    exp_q.push_back(16'h5A5A);
    start_req(1'b1, 32'h0800_0300, 2'b11, 16'h0);
    wait_done(1'b1);
    check("post_rst_ack_at", ack_at, 4);
    check("post_rst_ack_err", {ack_n[15:0], err_n[15:0]}, {16'd1, 16'd0});

    check("never_ack_and_err", both_cnt, 0);
    check("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
